// File: rtl/run_sequencer_if.sv
// Host/core/memory bundle of the run sequencer. The sequencer takes the master
// view; the host/testbench side takes the slave view.
interface run_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              ack;
  logic              timeout;
  logic              halt;
  logic              core_init;
  logic              core_stall;
  logic              core_mem_read;
  logic              core_mem_write;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [CNT_W-1:0]  cycle_count;
  logic [1:0]        state;

  modport master (
    input  start, halt, core_mem_read, core_mem_write, core_addr, core_wdata,
           host_req, host_we, host_addr, host_wdata,
    output ack, timeout, core_init, core_stall, host_gnt,
           mem_addr, mem_wdata, mem_we, mem_re, cycle_count, state
  );

  modport slave (
    output start, halt, core_mem_read, core_mem_write, core_addr, core_wdata,
           host_req, host_we, host_addr, host_wdata,
    input  ack, timeout, core_init, core_stall, host_gnt,
           mem_addr, mem_wdata, mem_we, mem_re, cycle_count, state
  );
endinterface

// File: rtl/run_sequencer.sv
// Run controller for the single-cycle core: IDLE/INIT/RUN/DONE sequencing, data-memory
// port arbitration, HALT detection and cycle counting. Optional: RUN_SEQ_HOST_PEEK_EN.
module run_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 16,
  parameter int INIT_CYCLES = 2,
  parameter int MAX_CYCLES  = 16'hFFFF
) (
  input  logic            CLK,
  input  logic            Reset,
  run_sequencer_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0]       INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(MAX_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic             ack_q, ack_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       init_q, init_d;

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    init_d    = init_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // Status is cleared on the way into INIT so ack is already low there.
        if (bus.start) begin
          state_d   = S_INIT;
          ack_d     = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          init_d    = '0;
        end
      end
      S_INIT: begin
        if (init_q == INIT_LAST) begin
          state_d = S_RUN;
          init_d  = '0;
        end else begin
          init_d = init_q + 4'd1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.halt) begin
          state_d   = S_DONE;
          ack_d     = 1'b1;
          timeout_d = 1'b0;
        end else if (cnt_q >= LIMIT_M1) begin
          state_d   = S_DONE;
          ack_d     = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      init_q    <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      init_q    <= init_d;
    end
  end

  logic              host_own;
  logic              core_req;
  logic              gnt;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mwdata;
  logic              mwe;
  logic              mre;

  assign host_own = (state_q == S_IDLE) || (state_q == S_DONE);
  assign core_req = bus.core_mem_read || bus.core_mem_write;

  // Port mux; every data-path output is zero when nobody is granted.
  always_comb begin
    gnt    = 1'b0;
    maddr  = '0;
    mwdata = '0;
    mwe    = 1'b0;
    mre    = 1'b0;
    if (host_own && bus.host_req) begin
      gnt    = 1'b1;
      maddr  = bus.host_addr;
      mwdata = bus.host_wdata;
      mwe    = bus.host_we;
      mre    = ~bus.host_we;
    end else if (state_q == S_RUN) begin
      if (core_req) begin
        maddr  = bus.core_addr;
        mwdata = bus.core_wdata;
        mwe    = bus.core_mem_write;
        mre    = bus.core_mem_read & ~bus.core_mem_write;
      end
`ifdef RUN_SEQ_HOST_PEEK_EN
      else if (bus.host_req && !bus.host_we) begin
        gnt   = 1'b1;
        maddr = bus.host_addr;
        mre   = 1'b1;
      end
`endif
    end
  end

  assign bus.host_gnt    = gnt;
  assign bus.mem_addr    = maddr;
  assign bus.mem_wdata   = mwdata;
  assign bus.mem_we      = mwe;
  assign bus.mem_re      = mre;
  assign bus.state       = state_q;
  assign bus.ack         = ack_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cnt_q;
  assign bus.core_init   = (state_q == S_IDLE) || (state_q == S_INIT);
  assign bus.core_stall  = (state_q != S_RUN);

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer (INIT_CYCLES=2, MAX_CYCLES=8).
module tb_run_sequencer;
  localparam int ADDR_W = 8, DATA_W = 8, CNT_W = 16, INIT_CYCLES = 2, MAX_CYCLES = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  run_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  run_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .INIT_CYCLES(INIT_CYCLES), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .CLK(clk), .Reset(rst), .bus(bus.master)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.start = 0; bus.halt = 0; bus.core_mem_read = 0; bus.core_mem_write = 0;
    bus.core_addr = 0; bus.core_wdata = 0; bus.host_req = 0; bus.host_we = 0;
    bus.host_addr = 0; bus.host_wdata = 0;
  endtask

  // From IDLE/DONE: pulse start, spend two INIT cycles, return in the first RUN cycle.
  task automatic go_to_run;
    bus.start = 1; step; bus.start = 0; step; step;
  endtask

  task automatic test_reset;
    clear_inputs;
    #2;
    vectors++; if (bus.state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    vectors++; if (bus.ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
    vectors++; if (bus.timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
    vectors++; if (bus.cycle_count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", bus.cycle_count); end
    vectors++; if ({bus.core_init, bus.core_stall} !== 2'b11) begin miscompares++; $display("FAIL reset_core_ctl: got %b want 11", {bus.core_init, bus.core_stall}); end
    step; rst = 1'b0; step;
  endtask

  task automatic test_host_idle;
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h10; bus.host_wdata = 8'hA5; #1;
    vectors++; if ({bus.host_gnt, bus.mem_we, bus.mem_re} !== 3'b110) begin miscompares++; $display("FAIL idle_wr_ctl: got %b want 110", {bus.host_gnt, bus.mem_we, bus.mem_re}); end
    vectors++; if ({bus.mem_addr, bus.mem_wdata} !== 16'h10A5) begin miscompares++; $display("FAIL idle_wr_bus: got %h want 10a5", {bus.mem_addr, bus.mem_wdata}); end
    vectors++; if (bus.state !== 2'd0) begin miscompares++; $display("FAIL idle_state: got %0d want 0", bus.state); end
    bus.host_we = 0; bus.host_addr = 8'h33; #1;
    vectors++; if ({bus.host_gnt, bus.mem_we, bus.mem_re, bus.mem_addr} !== {3'b101, 8'h33}) begin miscompares++; $display("FAIL idle_rd: got %h want 533", {bus.host_gnt, bus.mem_we, bus.mem_re, bus.mem_addr}); end
    bus.host_req = 0; #1;
    vectors++; if ({bus.host_gnt, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata} !== 19'd0) begin miscompares++; $display("FAIL idle_nogrant: got %h want 0", {bus.host_gnt, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata}); end
    clear_inputs;
  endtask

  task automatic test_run_halt;
    bus.start = 1; step; bus.start = 0;
    vectors++; if ({bus.state, bus.core_init, bus.core_stall} !== 4'b0111) begin miscompares++; $display("FAIL init1: got %b want 0111", {bus.state, bus.core_init, bus.core_stall}); end
    step;
    vectors++; if (bus.state !== 2'd1) begin miscompares++; $display("FAIL init2: got %0d want 1", bus.state); end
    step;
    vectors++; if ({bus.state, bus.core_init, bus.core_stall} !== 4'b1000) begin miscompares++; $display("FAIL run_entry: got %b want 1000", {bus.state, bus.core_init, bus.core_stall}); end
    for (int i = 0; i < 4; i++) step;
    vectors++; if ({bus.state, bus.cycle_count} !== {2'd2, 16'd4}) begin miscompares++; $display("FAIL run_cycle5: got %h want 20004", {bus.state, bus.cycle_count}); end
    bus.halt = 1; step; bus.halt = 0;
    vectors++; if ({bus.state, bus.ack, bus.timeout} !== 4'b1110) begin miscompares++; $display("FAIL halt_done: got %b want 1110", {bus.state, bus.ack, bus.timeout}); end
    vectors++; if (bus.cycle_count !== 16'd5) begin miscompares++; $display("FAIL halt_count: got %0d want 5", bus.cycle_count); end
    vectors++; if ({bus.core_init, bus.core_stall} !== 2'b01) begin miscompares++; $display("FAIL done_core_ctl: got %b want 01", {bus.core_init, bus.core_stall}); end
  endtask

  task automatic test_restart_arbitration;
    bus.start = 1; step; bus.start = 0;
    vectors++; if ({bus.state, bus.ack, bus.cycle_count} !== {2'd1, 1'b0, 16'd0}) begin miscompares++; $display("FAIL restart_init: got %h want 20000", {bus.state, bus.ack, bus.cycle_count}); end
    step; step;
    bus.core_mem_write = 1; bus.core_addr = 8'h20; bus.core_wdata = 8'h3C;
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h10; bus.host_wdata = 8'hA5; #1;
    vectors++; if ({bus.host_gnt, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata} !== {3'b010, 16'h203C}) begin miscompares++; $display("FAIL core_wr_prio: got %h want 2203c", {bus.host_gnt, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata}); end
    step; bus.core_mem_read = 1; #1;
    vectors++; if ({bus.mem_we, bus.mem_re} !== 2'b10) begin miscompares++; $display("FAIL core_rw_prio: got %b want 10", {bus.mem_we, bus.mem_re}); end
    step; bus.core_mem_write = 0; bus.core_addr = 8'h44; #1;
    vectors++; if ({bus.host_gnt, bus.mem_we, bus.mem_re, bus.mem_addr} !== {3'b001, 8'h44}) begin miscompares++; $display("FAIL core_rd: got %h want 144", {bus.host_gnt, bus.mem_we, bus.mem_re, bus.mem_addr}); end
    step; bus.core_mem_read = 0; bus.host_we = 0; bus.host_addr = 8'h55; #1;
`ifdef RUN_SEQ_HOST_PEEK_EN
    vectors++; if ({bus.host_gnt, bus.mem_we, bus.mem_re, bus.mem_addr} !== {3'b101, 8'h55}) begin miscompares++; $display("FAIL peek_rd: got %h want 555", {bus.host_gnt, bus.mem_we, bus.mem_re, bus.mem_addr}); end
`else
    vectors++; if ({bus.host_gnt, bus.mem_we, bus.mem_re, bus.mem_addr} !== 11'd0) begin miscompares++; $display("FAIL run_host_rd_denied: got %h want 0", {bus.host_gnt, bus.mem_we, bus.mem_re, bus.mem_addr}); end
`endif
    step; bus.host_we = 1; bus.halt = 1; #1;
    vectors++; if ({bus.host_gnt, bus.mem_we, bus.mem_re} !== 3'b000) begin miscompares++; $display("FAIL run_host_wr_denied: got %b want 000", {bus.host_gnt, bus.mem_we, bus.mem_re}); end
    step; clear_inputs;
    vectors++; if ({bus.state, bus.ack, bus.timeout, bus.cycle_count} !== {4'b1110, 16'd5}) begin miscompares++; $display("FAIL rerun_done: got %h want e0005", {bus.state, bus.ack, bus.timeout, bus.cycle_count}); end
  endtask

  task automatic test_timeout;
    go_to_run;
    bus.start = 1;
    for (int i = 0; i < 3; i++) step;
    bus.start = 0;
    vectors++; if (bus.state !== 2'd2) begin miscompares++; $display("FAIL start_in_run: got %0d want 2", bus.state); end
    for (int i = 0; i < 4; i++) step;
    vectors++; if ({bus.state, bus.cycle_count} !== {2'd2, 16'd7}) begin miscompares++; $display("FAIL pre_limit: got %h want 20007", {bus.state, bus.cycle_count}); end
    step;
    vectors++; if ({bus.state, bus.ack, bus.timeout} !== 4'b1111) begin miscompares++; $display("FAIL timeout_done: got %b want 1111", {bus.state, bus.ack, bus.timeout}); end
    vectors++; if (bus.cycle_count !== 16'd8) begin miscompares++; $display("FAIL timeout_count: got %0d want 8", bus.cycle_count); end
    step;
    vectors++; if ({bus.state, bus.cycle_count} !== {2'd3, 16'd8}) begin miscompares++; $display("FAIL done_hold: got %h want 30008", {bus.state, bus.cycle_count}); end
  endtask

  task automatic test_halt_at_limit;
    bus.start = 1; step; bus.start = 0;
    vectors++; if ({bus.ack, bus.timeout} !== 2'b00) begin miscompares++; $display("FAIL init_clears_status: got %b want 00", {bus.ack, bus.timeout}); end
    step; step;
    for (int i = 0; i < 7; i++) step;
    bus.halt = 1; step; bus.halt = 0;
    vectors++; if ({bus.state, bus.ack, bus.timeout, bus.cycle_count} !== {4'b1110, 16'd8}) begin miscompares++; $display("FAIL halt_wins: got %h want e0008", {bus.state, bus.ack, bus.timeout, bus.cycle_count}); end
  endtask

  task automatic test_async_reset;
    go_to_run;
    step; step;
    bus.core_mem_write = 1; bus.core_addr = 8'h20; #1;
    vectors++; if (bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL pre_reset_we: got %b want 1", bus.mem_we); end
    #1 rst = 1'b1; #1;
    vectors++; if ({bus.state, bus.core_init, bus.ack, bus.mem_we} !== 5'b00100) begin miscompares++; $display("FAIL async_reset_ctl: got %b want 00100", {bus.state, bus.core_init, bus.ack, bus.mem_we}); end
    vectors++; if (bus.cycle_count !== 16'd0) begin miscompares++; $display("FAIL async_reset_count: got %0d want 0", bus.cycle_count); end
    clear_inputs;
    step; rst = 1'b0; step;
    go_to_run;
    bus.halt = 1; step; bus.halt = 0;
    vectors++; if ({bus.state, bus.timeout, bus.cycle_count} !== {3'b110, 16'd1}) begin miscompares++; $display("FAIL post_reset_run: got %h want 60001", {bus.state, bus.timeout, bus.cycle_count}); end
  endtask

  initial begin
    test_reset;
    test_host_idle;
    test_run_halt;
    test_restart_arbitration;
    test_timeout;
    test_halt_at_limit;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
